// File: rtl/axi_cut_pkg.sv
// Shared types for the AXI register slice: per-channel cut modes and the
// default AXI4+ATOP channel/request/response structs used by the top.
package axi_cut_pkg;

    typedef enum logic [1:0] {
        CUT_BYPASS = 2'd0,
        CUT_FWD    = 2'd1,
        CUT_SPILL  = 2'd2
    } cut_mode_e;

    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 64;
    localparam int unsigned DataW = 64;
    localparam int unsigned UserW = 1;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [3:0]       region;
        logic [5:0]       atop;
        logic [UserW-1:0] user;
    } axi_aw_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
        logic [UserW-1:0]   user;
    } axi_w_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [1:0]       resp;
        logic [UserW-1:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [3:0]       region;
        logic [UserW-1:0] user;
    } axi_ar_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
        logic [UserW-1:0] user;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        axi_b_t  b;
        logic    b_valid;
        logic    ar_ready;
        axi_r_t  r;
        logic    r_valid;
    } axi_resp_t;

endpackage

// File: rtl/axi_cut_chan.sv
// Single valid/ready channel stage: combinational bypass, forward register
// (ready path kept combinational) or two-entry spill register (ready registered).
module axi_cut_chan
    import axi_cut_pkg::*;
#(
    parameter type       T    = logic,
    parameter cut_mode_e Mode = CUT_SPILL
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    if (Mode == CUT_BYPASS) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign out_valid      = in_valid;
        assign in_ready       = out_ready;
        assign out_data       = in_data;
    end else if (Mode == CUT_FWD) begin : g_fwd
        logic full;
        T     data;

        assign in_ready  = !full || out_ready;
        assign out_valid = full;
        assign out_data  = data;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                full <= 1'b0;
                data <= '0;
            end else if (in_valid && in_ready) begin
                full <= 1'b1;
                data <= in_data;
            end else if (out_ready) begin
                full <= 1'b0;
            end
        end
    end else begin : g_spill
        logic a_full, b_full;
        T     a_data, b_data;
        logic push, pop;

        assign in_ready  = !b_full;
        assign out_valid = a_full;
        assign out_data  = a_data;
        assign push      = in_valid && !b_full;
        assign pop       = a_full && out_ready;

        // A push implies B is empty, so a concurrent pop frees A for the new beat.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                a_full <= 1'b0;
                b_full <= 1'b0;
                a_data <= '0;
                b_data <= '0;
            end else begin
                if (pop) begin
                    if (b_full) begin
                        a_data <= b_data;
                        b_full <= 1'b0;
                    end else begin
                        a_full <= 1'b0;
                    end
                end
                if (push) begin
                    if (!a_full || pop) begin
                        a_data <= in_data;
                        a_full <= 1'b1;
                    end else begin
                        b_data <= in_data;
                        b_full <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/axi_cut_rev.sv
// AXI4+ATOP register slice: each of AW/W/B/AR/R is cut independently,
// payload (including atop and user) is carried bit-exact.
module axi_cut_rev
    import axi_cut_pkg::*;
#(
    parameter type       aw_chan_t = axi_aw_t,
    parameter type       w_chan_t  = axi_w_t,
    parameter type       b_chan_t  = axi_b_t,
    parameter type       ar_chan_t = axi_ar_t,
    parameter type       r_chan_t  = axi_r_t,
    parameter type       req_t     = axi_req_t,
    parameter type       resp_t    = axi_resp_t,
    parameter cut_mode_e AwMode    = CUT_SPILL,
    parameter cut_mode_e WMode     = CUT_SPILL,
    parameter cut_mode_e BMode     = CUT_SPILL,
    parameter cut_mode_e ArMode    = CUT_SPILL,
    parameter cut_mode_e RMode     = CUT_SPILL
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o,
    output req_t  mst_req_o,
    input  resp_t mst_resp_i
);

    aw_chan_t aw_out;
    w_chan_t  w_out;
    b_chan_t  b_out;
    ar_chan_t ar_out;
    r_chan_t  r_out;
    logic aw_out_valid, w_out_valid, b_out_valid, ar_out_valid, r_out_valid;
    logic aw_in_ready, w_in_ready, b_in_ready, ar_in_ready, r_in_ready;

    axi_cut_chan #(.T(aw_chan_t), .Mode(AwMode)) u_aw (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid(slv_req_i.aw_valid), .in_ready(aw_in_ready), .in_data(slv_req_i.aw),
        .out_valid(aw_out_valid), .out_ready(mst_resp_i.aw_ready), .out_data(aw_out)
    );

    axi_cut_chan #(.T(w_chan_t), .Mode(WMode)) u_w (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid(slv_req_i.w_valid), .in_ready(w_in_ready), .in_data(slv_req_i.w),
        .out_valid(w_out_valid), .out_ready(mst_resp_i.w_ready), .out_data(w_out)
    );

    axi_cut_chan #(.T(b_chan_t), .Mode(BMode)) u_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid(mst_resp_i.b_valid), .in_ready(b_in_ready), .in_data(mst_resp_i.b),
        .out_valid(b_out_valid), .out_ready(slv_req_i.b_ready), .out_data(b_out)
    );

    axi_cut_chan #(.T(ar_chan_t), .Mode(ArMode)) u_ar (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid(slv_req_i.ar_valid), .in_ready(ar_in_ready), .in_data(slv_req_i.ar),
        .out_valid(ar_out_valid), .out_ready(mst_resp_i.ar_ready), .out_data(ar_out)
    );

    axi_cut_chan #(.T(r_chan_t), .Mode(RMode)) u_r (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid(mst_resp_i.r_valid), .in_ready(r_in_ready), .in_data(mst_resp_i.r),
        .out_valid(r_out_valid), .out_ready(slv_req_i.r_ready), .out_data(r_out)
    );

    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = aw_out;
        mst_req_o.aw_valid = aw_out_valid;
        mst_req_o.w        = w_out;
        mst_req_o.w_valid  = w_out_valid;
        mst_req_o.b_ready  = b_in_ready;
        mst_req_o.ar       = ar_out;
        mst_req_o.ar_valid = ar_out_valid;
        mst_req_o.r_ready  = r_in_ready;

        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_in_ready;
        slv_resp_o.w_ready  = w_in_ready;
        slv_resp_o.b        = b_out;
        slv_resp_o.b_valid  = b_out_valid;
        slv_resp_o.ar_ready = ar_in_ready;
        slv_resp_o.r        = r_out;
        slv_resp_o.r_valid  = r_out_valid;
    end

endmodule

// File: tb/tb_axi_cut_rev.sv
// Bench for axi_cut_rev with AW/W/R spill, AR forward and B bypass.
module tb_axi_cut_rev;
    import axi_cut_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    axi_req_t  slv_req, mst_req;
    axi_resp_t slv_resp, mst_resp;
    int        total = 0;
    int        bad = 0;

    always #5 clk = ~clk;

    axi_cut_rev #(
        .AwMode(CUT_SPILL), .WMode(CUT_SPILL), .BMode(CUT_BYPASS),
        .ArMode(CUT_FWD), .RMode(CUT_SPILL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_req_i(slv_req), .slv_resp_o(slv_resp),
        .mst_req_o(mst_req), .mst_resp_i(mst_resp)
    );

    typedef struct {
        logic       valid;
        logic [3:0] id;
        logic [1:0] resp;
        logic       rdy;
        logic       exp_valid;
        logic [3:0] exp_id;
        logic [1:0] exp_resp;
        logic       exp_rdy;
    } bvec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bvec_t       tbl[4];
        logic [63:0] got[$];
        int          k;
        int          cnt;
        logic        pushed;

        tbl[0] = '{1'b1, 4'd5, 2'd2, 1'b1, 1'b1, 4'd5, 2'd2, 1'b1};
        tbl[1] = '{1'b1, 4'd5, 2'd2, 1'b0, 1'b1, 4'd5, 2'd2, 1'b0};
        tbl[2] = '{1'b0, 4'd0, 2'd0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b1};
        tbl[3] = '{1'b1, 4'hA, 2'd3, 1'b1, 1'b1, 4'hA, 2'd3, 1'b1};

        slv_req  = '0;
        mst_resp = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_aw_valid", mst_req.aw_valid, 0);
        chk("rst_w_valid", mst_req.w_valid, 0);
        chk("rst_ar_valid", mst_req.ar_valid, 0);
        chk("rst_r_valid", slv_resp.r_valid, 0);
        chk("rst_aw_ready", slv_resp.aw_ready, 1);
        chk("rst_w_ready", slv_resp.w_ready, 1);
        chk("rst_r_ready", mst_req.r_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        cyc();

        // AW spill: one-cycle latency, atop carried through
        mst_resp.aw_ready = 1'b1;
        slv_req.aw.id     = 4'd3;
        slv_req.aw.addr   = 64'h8000_0040;
        slv_req.aw.atop   = 6'h21;
        slv_req.aw_valid  = 1'b1;
        #1;
        chk("aw_ready_c0", slv_resp.aw_ready, 1);
        chk("aw_valid_c0", mst_req.aw_valid, 0);
        cyc();
        chk("aw_valid_c1", mst_req.aw_valid, 1);
        chk("aw_id", mst_req.aw.id, 3);
        chk("aw_addr", mst_req.aw.addr, 64'h8000_0040);
        chk("aw_atop", mst_req.aw.atop, 6'h21);
        chk("aw_ready_c1", slv_resp.aw_ready, 1);
        cyc();
        chk("aw_valid_c2", mst_req.aw_valid, 1);
        chk("aw_ready_c2", slv_resp.aw_ready, 1);
        slv_req.aw_valid = 1'b0;
        cyc();
        chk("aw_valid_drain", mst_req.aw_valid, 0);

        // R spill: 8-beat burst streams at full rate
        slv_req.r_ready = 1'b1;
        mst_resp.r.id   = 4'd2;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                mst_resp.r_valid = 1'b1;
                mst_resp.r.data  = 64'(i);
                mst_resp.r.last  = (i == 7);
            end else begin
                mst_resp.r_valid = 1'b0;
            end
            #1;
            if (i < 8) chk("r_in_ready", mst_req.r_ready, 1);
            if (i > 0) begin
                chk("r_valid", slv_resp.r_valid, 1);
                chk("r_data", slv_resp.r.data, 64'(i - 1));
                chk("r_last", slv_resp.r.last, (i == 8) ? 1 : 0);
            end
            cyc();
        end
        #1;
        chk("r_valid_end", slv_resp.r_valid, 0);

        // W spill: downstream stall absorbs one beat, nothing lost or duplicated
        slv_req.w.strb = 8'hff;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            mst_resp.w_ready = !(c >= 3 && c <= 5);
            slv_req.w_valid  = (k < 8);
            slv_req.w.data   = 64'h100 + 64'(k);
            slv_req.w.last   = (k == 7);
            #1;
            if (c == 3) chk("w_absorb_ready", slv_resp.w_ready, 1);
            if (c == 4) begin
                chk("w_stall_ready", slv_resp.w_ready, 0);
                chk("w_stall_valid", mst_req.w_valid, 1);
                chk("w_stall_data", mst_req.w.data, 64'h102);
            end
            pushed = slv_req.w_valid && slv_resp.w_ready;
            if (mst_req.w_valid && mst_resp.w_ready) got.push_back(mst_req.w.data);
            cyc();
            if (pushed) k++;
        end
        chk("w_beats", 64'(got.size()), 8);
        for (int j = 0; j < 8; j++) begin
            if (j < got.size()) chk("w_order", got[j], 64'h100 + 64'(j));
        end

        // AR forward: ready drops combinationally once full
        mst_resp.ar_ready = 1'b0;
        slv_req.ar.addr   = 64'h1000;
        slv_req.ar_valid  = 1'b1;
        #1;
        chk("ar_ready_empty", slv_resp.ar_ready, 1);
        chk("ar_valid_c0", mst_req.ar_valid, 0);
        cyc();
        slv_req.ar_valid = 1'b0;
        #1;
        chk("ar_valid_full", mst_req.ar_valid, 1);
        chk("ar_addr", mst_req.ar.addr, 64'h1000);
        chk("ar_ready_full", slv_resp.ar_ready, 0);
        cyc();
        chk("ar_hold_valid", mst_req.ar_valid, 1);
        mst_resp.ar_ready = 1'b1;
        #1;
        chk("ar_ready_comb", slv_resp.ar_ready, 1);
        cnt = 0;
        for (int n = 0; n < 4; n++) begin
            if (mst_req.ar_valid && mst_resp.ar_ready) cnt++;
            cyc();
        end
        chk("ar_transfers", 64'(cnt), 1);

        // B bypass: table of combinational vectors
        for (int t = 0; t < 4; t++) begin
            mst_resp.b_valid = tbl[t].valid;
            mst_resp.b.id    = tbl[t].id;
            mst_resp.b.resp  = tbl[t].resp;
            slv_req.b_ready  = tbl[t].rdy;
            #1;
            chk("b_valid", slv_resp.b_valid, tbl[t].exp_valid);
            if (tbl[t].exp_valid) begin
                chk("b_id", slv_resp.b.id, tbl[t].exp_id);
                chk("b_resp", slv_resp.b.resp, tbl[t].exp_resp);
            end
            chk("b_ready", mst_req.b_ready, tbl[t].exp_rdy);
        end
        mst_resp.b_valid = 1'b0;
        cyc();

        // Reset with AW and R spill registers both full
        mst_resp.aw_ready = 1'b0;
        slv_req.aw.id     = 4'd1;
        slv_req.aw.addr   = 64'h40;
        slv_req.aw_valid  = 1'b1;
        slv_req.r_ready   = 1'b0;
        mst_resp.r_valid  = 1'b1;
        mst_resp.r.data   = 64'hAA;
        cyc();
        cyc();
        chk("full_aw_ready", slv_resp.aw_ready, 0);
        chk("full_r_ready", mst_req.r_ready, 0);
        chk("full_aw_valid", mst_req.aw_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_aw_valid", mst_req.aw_valid, 0);
        chk("arst_r_valid", slv_resp.r_valid, 0);
        chk("arst_aw_ready", slv_resp.aw_ready, 1);
        chk("arst_r_ready", mst_req.r_ready, 1);
        slv_req.aw_valid = 1'b0;
        mst_resp.r_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        cyc();
        mst_resp.aw_ready = 1'b1;
        slv_req.aw.id     = 4'd7;
        slv_req.aw.addr   = 64'hDE_ADBE_EF00;
        slv_req.aw.atop   = 6'h05;
        slv_req.aw.user   = 1'b1;
        slv_req.aw_valid  = 1'b1;
        cyc();
        slv_req.aw_valid = 1'b0;
        #1;
        chk("post_aw_valid", mst_req.aw_valid, 1);
        chk("post_aw_id", mst_req.aw.id, 7);
        chk("post_aw_addr", mst_req.aw.addr, 64'hDE_ADBE_EF00);
        chk("post_aw_atop", mst_req.aw.atop, 6'h05);
        chk("post_aw_user", mst_req.aw.user, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
